// File: rtl/rs15_9_pkg.sv
// Shared GF(2^4) definitions for the RS(15,9) decoder path: field constants,
// the symbol type, the syndrome FSM state type and a constant-power multiplier.
package rs15_9_pkg;

  localparam int         SYM_W   = 4;
  localparam int         N_SYM   = 15;
  localparam int         K_SYM   = 9;
  localparam int         N_SYN   = 6;
  localparam logic [4:0] GF_POLY = 5'b10011;

  typedef logic [SYM_W-1:0] gf16_t;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Multiply by alpha (x): shift left, fold x^4 back as x+1.
  function automatic gf16_t gf16_xtime(input gf16_t a);
    gf16_t r;
    r = {a[SYM_W-2:0], 1'b0};
    if (a[SYM_W-1]) r = r ^ GF_POLY[SYM_W-1:0];
    return r;
  endfunction

  // With a constant power this unrolls into a pure XOR network.
  function automatic gf16_t gf16_mul_const(input gf16_t sym, input int power);
    gf16_t acc;
    acc = sym;
    for (int i = 0; i < N_SYM - 1; i++) begin
      if (i < (power % N_SYM)) acc = gf16_xtime(acc);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_syndrome_if.sv
// Symbol input and syndrome output handshakes of the RS(15,9) syndrome block.
interface rs_syndrome_if #(
   parameter int SYM_W = 4,
   parameter int N_SYN = 6
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_sop;
   logic [SYM_W-1:0]       in_sym;
   logic                   synd_valid;
   logic                   synd_ready;
   logic [N_SYN*SYM_W-1:0] synd;
   logic                   synd_nz;
   logic                   frame_err;

   modport master (
      output in_valid, in_sop, in_sym, synd_ready,
      input  in_ready, synd_valid, synd, synd_nz, frame_err
   );

   modport slave (
      input  in_valid, in_sop, in_sym, synd_ready,
      output in_ready, synd_valid, synd, synd_nz, frame_err
   );
endinterface

// File: rtl/rs_gf16_alpha_mul.sv
// Constant multiplier by alpha^P in GF(16), built as an XOR network.
module rs_gf16_alpha_mul
   import rs15_9_pkg::*;
#(
   parameter int P = 1
) (
   input  gf16_t i_sym,
   output gf16_t o_prod
);
   assign o_prod = gf16_mul_const(i_sym, P);
endmodule

// File: rtl/rs_syndrome.sv
// Serial RS(15,9) syndrome calculator: Horner evaluation of S1..S6 over one
// 15-symbol codeword, handed downstream as one registered word per frame.
module rs_syndrome
   import rs15_9_pkg::*;
#(
   parameter int SYM_W = 4,
   parameter int N_SYM = 15,
   parameter int N_SYN = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   rs_syndrome_if.slave bus
);

   localparam logic [3:0] LAST_CNT = 4'(N_SYM - 1);

   if (SYM_W != 4) begin : g_bad_sym_w
      $error("rs_syndrome only supports SYM_W = 4");
   end

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic                   r_in_ready;
   logic                   r_synd_valid;
   logic [N_SYN*SYM_W-1:0] r_synd;
   logic                   r_synd_nz;
   logic                   r_frame_err;
   gf16_t                  r_s    [N_SYN];
   gf16_t                  w_mul  [N_SYN];
   gf16_t                  w_next [N_SYN];
   logic [N_SYN*SYM_W-1:0] w_pack;
   logic                   w_xfer;

   assign w_xfer = bus.in_valid & r_in_ready;

   for (genvar j = 0; j < N_SYN; j++) begin : g_syn
      rs_gf16_alpha_mul #(.P(j + 1)) u_mul (
         .i_sym  (r_s[j]),
         .o_prod (w_mul[j])
      );
      assign w_next[j]                  = w_mul[j] ^ bus.in_sym;
      assign w_pack[j*SYM_W +: SYM_W]   = w_next[j];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_in_ready   <= 1'b1;
         r_synd_valid <= 1'b0;
         r_synd       <= '0;
         r_synd_nz    <= 1'b0;
         r_frame_err  <= 1'b0;
         for (int j = 0; j < N_SYN; j++) r_s[j] <= '0;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  if (bus.in_sop) begin
                     for (int j = 0; j < N_SYN; j++) r_s[j] <= bus.in_sym;
                     r_cnt   <= 4'd1;
                     r_state <= ACCUM;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (w_xfer) begin
                  // A new sop restarts the frame, even on the final position.
                  if (bus.in_sop) begin
                     r_frame_err <= 1'b1;
                     for (int j = 0; j < N_SYN; j++) r_s[j] <= bus.in_sym;
                     r_cnt <= 4'd1;
                  end else if (r_cnt == LAST_CNT) begin
                     for (int j = 0; j < N_SYN; j++) r_s[j] <= w_next[j];
                     r_synd       <= w_pack;
                     r_synd_nz    <= |w_pack;
                     r_cnt        <= '0;
                     r_in_ready   <= 1'b0;
                     r_synd_valid <= 1'b1;
                     r_state      <= HOLD;
                  end else begin
                     for (int j = 0; j < N_SYN; j++) r_s[j] <= w_next[j];
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            HOLD: begin
               if (bus.synd_ready) begin
                  r_in_ready   <= 1'b1;
                  r_synd_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_in_ready   <= 1'b1;
               r_synd_valid <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.synd_valid = r_synd_valid;
   assign bus.synd       = r_synd;
   assign bus.synd_nz    = r_synd_nz;
   assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_rs_syndrome.sv
// Directed bench for rs_syndrome: hand-computed syndromes of single-symbol
// codewords plus handshake, backpressure, framing-error and reset scenarios.
module tb_rs_syndrome;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   rs_syndrome_if #(.SYM_W(4), .N_SYN(6)) bus ();

   rs_syndrome u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_sym(input logic sop, input logic [3:0] sym);
      bus.in_valid = 1'b1;
      bus.in_sop   = sop;
      bus.in_sym   = sym;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_sym   = 4'h0;
   endtask

   // One codeword r14..r0; only coefficient of degree pos is v.
   task automatic send_frame(input int pos, input logic [3:0] v, input bit gaps);
      for (int i = 0; i < 15; i++) begin
         send_sym(i == 0, ((14 - i) == pos) ? v : 4'h0);
         if (i == 13) chk("valid_before_last", 32'(bus.synd_valid), 32'd0);
         if (gaps && i < 14) idle_cyc(1);
      end
   endtask

   task automatic take_synd(input string tag, input logic [23:0] exp, input logic nz);
      chk({tag, "_valid"}, 32'(bus.synd_valid), 32'd1);
      chk({tag, "_rdy_low"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_synd"}, 32'(bus.synd), 32'(exp));
      chk({tag, "_nz"}, 32'(bus.synd_nz), 32'(nz));
      bus.synd_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.synd_ready = 1'b0;
      chk({tag, "_valid_clr"}, 32'(bus.synd_valid), 32'd0);
      chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_sop     = 1'b0;
      bus.in_sym     = 4'h0;
      bus.synd_ready = 1'b0;
      idle_cyc(3);
      chk("rst_valid", 32'(bus.synd_valid), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_synd", 32'(bus.synd), 32'd0);
      chk("rst_nz", 32'(bus.synd_nz), 32'd0);
      chk("rst_ferr", 32'(bus.frame_err), 32'd0);
      rst_n = 1'b1;
      idle_cyc(2);

      send_frame(-1, 4'h0, 1'b0);
      take_synd("zero", 24'h000000, 1'b0);
      send_frame(0, 4'h1, 1'b0);
      take_synd("r0", 24'h111111, 1'b1);
      send_frame(1, 4'h1, 1'b1);
      take_synd("r1_gaps", 24'hC63842, 1'b1);
      send_frame(14, 4'h1, 1'b0);
      take_synd("r14", 24'hA7EFD9, 1'b1);

      // Backpressure: sop offered continuously while the word is held.
      send_frame(1, 4'h1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_sop   = 1'b1;
      bus.in_sym   = 4'h5;
      for (int i = 0; i < 10; i++) begin
         idle_cyc(1);
         chk("bp_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_synd", 32'(bus.synd), 32'h00C63842);
      end
      chk("bp_ferr", 32'(bus.frame_err), 32'd0);
      bus.synd_ready = 1'b1;
      idle_cyc(1);
      bus.synd_ready = 1'b0;
      chk("bp_valid_clr", 32'(bus.synd_valid), 32'd0);
      chk("bp_rdy_back", 32'(bus.in_ready), 32'd1);
      send_frame(0, 4'h1, 1'b0);
      take_synd("bp_next", 24'h111111, 1'b1);

      // Truncated frame: sop on the 8th symbol restarts.
      send_sym(1'b1, 4'h3);
      for (int i = 0; i < 6; i++) send_sym(1'b0, 4'h3);
      send_sym(1'b1, 4'h0);
      chk("trunc_ferr", 32'(bus.frame_err), 32'd1);
      for (int i = 0; i < 14; i++) begin
         send_sym(1'b0, 4'h0);
         if (i == 0) chk("trunc_ferr_clr", 32'(bus.frame_err), 32'd0);
         if (i == 12) chk("trunc_no_early", 32'(bus.synd_valid), 32'd0);
      end
      take_synd("trunc", 24'h000000, 1'b0);
      idle_cyc(3);
      chk("trunc_one_word", 32'(bus.synd_valid), 32'd0);

      // sop on the 15th position: no word, new frame r14..r0 follows.
      send_sym(1'b1, 4'h7);
      for (int i = 0; i < 13; i++) send_sym(1'b0, 4'h7);
      send_sym(1'b1, 4'h0);
      chk("pos15_ferr", 32'(bus.frame_err), 32'd1);
      chk("pos15_no_word", 32'(bus.synd_valid), 32'd0);
      for (int i = 0; i < 14; i++) send_sym(1'b0, (i == 13) ? 4'h1 : 4'h0);
      take_synd("pos15", 24'h111111, 1'b1);

      // Symbol without sop in IDLE is dropped.
      send_sym(1'b0, 4'h9);
      chk("idle_ferr", 32'(bus.frame_err), 32'd1);
      chk("idle_ready", 32'(bus.in_ready), 32'd1);
      idle_cyc(1);
      chk("idle_ferr_clr", 32'(bus.frame_err), 32'd0);
      send_frame(14, 4'h1, 1'b0);
      take_synd("idle_next", 24'hA7EFD9, 1'b1);

      // Asynchronous reset at symbol 7.
      send_sym(1'b1, 4'h5);
      for (int i = 0; i < 6; i++) send_sym(1'b0, 4'hA);
      rst_n = 1'b0;
      #1;
      chk("arst_synd", 32'(bus.synd), 32'd0);
      chk("arst_nz", 32'(bus.synd_nz), 32'd0);
      chk("arst_valid", 32'(bus.synd_valid), 32'd0);
      chk("arst_ready", 32'(bus.in_ready), 32'd1);
      chk("arst_ferr", 32'(bus.frame_err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cyc(1);
      send_frame(1, 4'h1, 1'b0);
      take_synd("arst_r1", 24'hC63842, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
